// File: rtl/motor_sched_pkg.sv
// rtl/motor_sched_pkg.sv - shared state, stage and rate codes for the motor loop scheduler
package motor_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_CALC   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  localparam logic [1:0] STAGE_NONE   = 2'd0;
  localparam logic [1:0] STAGE_SAMPLE = 2'd1;
  localparam logic [1:0] STAGE_CALC   = 2'd2;
  localparam logic [1:0] STAGE_OUTPUT = 2'd3;

  localparam logic [3:0] RATE_128HZ  = 4'd0;
  localparam logic [3:0] RATE_256HZ  = 4'd1;
  localparam logic [3:0] RATE_512HZ  = 4'd2;
  localparam logic [3:0] RATE_1024HZ = 4'd3;

  function automatic logic [1:0] stage_of(state_e st);
    case (st)
      ST_SAMPLE: return STAGE_SAMPLE;
      ST_CALC:   return STAGE_CALC;
      ST_OUTPUT: return STAGE_OUTPUT;
      default:   return STAGE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/motor_sched_timer.sv
// rtl/motor_sched_timer.sv - per-state cycle counter; expired marks the last allowed cycle
module motor_sched_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  // Count stops at LAST so the flag stays up until the next state entry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/motor_loop_scheduler.sv
// rtl/motor_loop_scheduler.sv - sequences ADC sample, PID compute and DAC write per trigger edge
module motor_loop_scheduler
  import motor_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int OVR_W       = 16,
  parameter int LAT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             loop_en_i,
  input  logic [3:0]       freq_sel_i,
  input  logic             err_clr_i,
  input  logic             trig_i,
  output logic             gen_hold_o,
  output logic [3:0]       gen_freq_o,
  output logic             adc_req_o,
  input  logic             adc_ack_i,
  output logic             pid_start_o,
  input  logic             pid_done_i,
  output logic             dac_valid_o,
  input  logic             dac_ready_i,
  output logic             cycle_done_o,
  output logic             busy_o,
  output logic             err_to_o,
  output logic [1:0]       err_stage_o,
  output logic [OVR_W-1:0] overrun_cnt_o,
  output logic [LAT_W-1:0] cycle_lat_o
);

  state_e             state_q, state_d;
  logic               trig_dly_q, trig_dly_d;
  logic               gen_hold_q, gen_hold_d;
  logic [3:0]         gen_freq_q, gen_freq_d;
  logic               pid_start_q, pid_start_d;
  logic               cycle_done_q, cycle_done_d;
  logic               err_to_q, err_to_d;
  logic [1:0]         err_stage_q, err_stage_d;
  logic [OVR_W-1:0]   ovr_q, ovr_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [LAT_W-1:0]   cycle_lat_q, cycle_lat_d;
  logic [LAT_W-1:0]   lat_inc;
  logic               trig_edge, accept, overrun, dac_hs, expired, timeout;

  assign trig_edge = trig_i & ~trig_dly_q;
  assign accept    = (state_q == ST_IDLE) && trig_edge && loop_en_i;
  assign overrun   = (state_q != ST_IDLE) && trig_edge;
  assign dac_hs    = (state_q == ST_OUTPUT) && dac_ready_i;
  assign lat_inc   = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);

  motor_sched_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (state_d != state_q),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshakes are tested before expiry so the last allowed cycle still succeeds.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SAMPLE;
      ST_SAMPLE: if (adc_ack_i) state_d = ST_CALC;
                 else if (expired) begin state_d = ST_IDLE; timeout = 1'b1; end
      ST_CALC:   if (pid_done_i) state_d = ST_OUTPUT;
                 else if (expired) begin state_d = ST_IDLE; timeout = 1'b1; end
      ST_OUTPUT: if (dac_ready_i) state_d = ST_IDLE;
                 else if (expired) begin state_d = ST_IDLE; timeout = 1'b1; end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    adc_req_o   = (state_q == ST_SAMPLE);
    dac_valid_o = (state_q == ST_OUTPUT);
    busy_o      = (state_q != ST_IDLE);
  end

  always_comb begin
    trig_dly_d   = trig_i;
    gen_hold_d   = ~loop_en_i;
    gen_freq_d   = loop_en_i ? gen_freq_q : freq_sel_i;
    pid_start_d  = (state_d == ST_CALC) && (state_q != ST_CALC);
    cycle_done_d = dac_hs;
    cycle_lat_d  = dac_hs ? lat_inc : cycle_lat_q;
    lat_d        = accept ? '0 : (busy_o ? lat_inc : lat_q);
    err_to_d     = err_to_q;
    err_stage_d  = err_stage_q;
    ovr_d        = ovr_q;
    if (err_clr_i) begin
      err_to_d    = 1'b0;
      err_stage_d = STAGE_NONE;
      ovr_d       = '0;
    end
    // Events land after the clear so a coincident timeout or overrun survives it.
    if (timeout) begin
      if (!err_to_d) err_stage_d = stage_of(state_q);
      err_to_d = 1'b1;
    end
    if (overrun && (ovr_d != '1)) begin
      ovr_d = ovr_d + OVR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trig_dly_q   <= 1'b1;
      gen_hold_q   <= 1'b1;
      gen_freq_q   <= '0;
      pid_start_q  <= 1'b0;
      cycle_done_q <= 1'b0;
      cycle_lat_q  <= '0;
      lat_q        <= '0;
      err_to_q     <= 1'b0;
      err_stage_q  <= STAGE_NONE;
      ovr_q        <= '0;
    end else begin
      trig_dly_q   <= trig_dly_d;
      gen_hold_q   <= gen_hold_d;
      gen_freq_q   <= gen_freq_d;
      pid_start_q  <= pid_start_d;
      cycle_done_q <= cycle_done_d;
      cycle_lat_q  <= cycle_lat_d;
      lat_q        <= lat_d;
      err_to_q     <= err_to_d;
      err_stage_q  <= err_stage_d;
      ovr_q        <= ovr_d;
    end
  end

  assign gen_hold_o    = gen_hold_q;
  assign gen_freq_o    = gen_freq_q;
  assign pid_start_o   = pid_start_q;
  assign cycle_done_o  = cycle_done_q;
  assign cycle_lat_o   = cycle_lat_q;
  assign err_to_o      = err_to_q;
  assign err_stage_o   = err_stage_q;
  assign overrun_cnt_o = ovr_q;

endmodule

// File: tb/tb_motor_loop_scheduler.sv
// tb/tb_motor_loop_scheduler.sv - scoreboard bench for motor_loop_scheduler
module tb_motor_loop_scheduler;
  import motor_sched_pkg::*;

  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        loop_en = 1'b0;
  logic [3:0]  freq_sel = 4'd0;
  logic        err_clr = 1'b0;
  logic        trig = 1'b0;
  logic        adc_ack = 1'b0;
  logic        pid_done = 1'b0;
  logic        dac_ready = 1'b0;
  logic        gen_hold_o, adc_req_o, pid_start_o, dac_valid_o;
  logic        cycle_done_o, busy_o, err_to_o;
  logic [3:0]  gen_freq_o;
  logic [1:0]  err_stage_o;
  logic [15:0] overrun_cnt_o, cycle_lat_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int lat;
    int err_to;
    int ovr;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  motor_loop_scheduler #(.TIMEOUT_CYC(TO), .OVR_W(16), .LAT_W(16)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .loop_en_i     (loop_en),
    .freq_sel_i    (freq_sel),
    .err_clr_i     (err_clr),
    .trig_i        (trig),
    .gen_hold_o    (gen_hold_o),
    .gen_freq_o    (gen_freq_o),
    .adc_req_o     (adc_req_o),
    .adc_ack_i     (adc_ack),
    .pid_start_o   (pid_start_o),
    .pid_done_i    (pid_done),
    .dac_valid_o   (dac_valid_o),
    .dac_ready_i   (dac_ready),
    .cycle_done_o  (cycle_done_o),
    .busy_o        (busy_o),
    .err_to_o      (err_to_o),
    .err_stage_o   (err_stage_o),
    .overrun_cnt_o (overrun_cnt_o),
    .cycle_lat_o   (cycle_lat_o)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && cycle_done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cycle_done: got 1 expected 0");
      end else begin
        e = sb.pop_front();
        check("cycle_lat", int'(cycle_lat_o), e.lat);
        check("done_err_to", int'(err_to_o), e.err_to);
        check("done_overrun", int'(overrun_cnt_o), e.ovr);
      end
    end
  end

  // a/d/r: cycles of wait before ack, before done (after start), before ready.
  task automatic run_cycle(input int a, input int d, input int r, input int npulse,
                           input bit clr_pulse, input int exp_lat, input int exp_err,
                           input int exp_ovr);
    exp_t e;
    e.lat = exp_lat;
    e.err_to = exp_err;
    e.ovr = exp_ovr;
    sb.push_back(e);
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("adc_req_t1", int'(adc_req_o), 1);
    repeat (a) step();
    adc_ack = 1'b1;
    step();
    adc_ack = 1'b0;
    check("pid_start", int'(pid_start_o), 1);
    for (int i = 0; i < d; i++) begin
      if (i == 1) check("pid_start_one_cycle", int'(pid_start_o), 0);
      trig = (i < 20 * npulse) && (i % 20 == 10);
      err_clr = clr_pulse && trig;
      step();
    end
    trig = 1'b0;
    err_clr = 1'b0;
    pid_done = 1'b1;
    step();
    pid_done = 1'b0;
    check("dac_valid", int'(dac_valid_o), 1);
    repeat (r) step();
    dac_ready = 1'b1;
    step();
    dac_ready = 1'b0;
    check("idle_after_hs", int'(busy_o), 0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    freq_sel = RATE_1024HZ;
    trig = 1'b1;
    repeat (3) step();
    check("rst_gen_hold", int'(gen_hold_o), 1);
    check("rst_gen_freq", int'(gen_freq_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_adc_req", int'(adc_req_o), 0);
    check("rst_dac_valid", int'(dac_valid_o), 0);
    check("rst_err_to", int'(err_to_o), 0);
    check("rst_overrun", int'(overrun_cnt_o), 0);
    check("rst_cycle_lat", int'(cycle_lat_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) step();
    check("hold_while_disabled", int'(gen_hold_o), 1);
    check("freq_loaded", int'(gen_freq_o), 3);
    check("no_cycle_trig_high", int'(busy_o), 0);
    loop_en = 1'b1;
    step();
    freq_sel = RATE_128HZ;
    repeat (2) step();
    check("freq_frozen", int'(gen_freq_o), 3);
    check("hold_released", int'(gen_hold_o), 0);
    check("no_cycle_level_trig", int'(busy_o), 0);
    trig = 1'b0;
    step();

    run_cycle(0, 10, 0, 0, 1'b0, 13, 0, 0);
    run_cycle(0, 0, 0, 0, 1'b0, 3, 0, 0);
    run_cycle(2, 1, 3, 0, 1'b0, 9, 0, 0);
    run_cycle(0, 300, 0, 3, 1'b0, 303, 0, 3);
    run_cycle(0, 0, TO - 1, 0, 1'b0, 1002, 0, 3);
    run_cycle(0, 20, 0, 1, 1'b1, 23, 0, 1);

    trig = 1'b1;
    step();
    trig = 1'b0;
    n = 0;
    while (adc_req_o && n < 2 * TO) begin
      n++;
      step();
    end
    check("adc_req_cycles", n, TO);
    check("to_err", int'(err_to_o), 1);
    check("to_stage", int'(err_stage_o), 1);
    check("to_idle", int'(busy_o), 0);
    check("to_overrun_kept", int'(overrun_cnt_o), 1);

    trig = 1'b1;
    step();
    trig = 1'b0;
    adc_ack = 1'b1;
    step();
    adc_ack = 1'b0;
    n = 0;
    while (busy_o && n < 2 * TO) begin
      n++;
      step();
    end
    check("calc_cycles", n, TO);
    check("to2_err", int'(err_to_o), 1);
    check("to2_stage_first", int'(err_stage_o), 1);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_err_to", int'(err_to_o), 0);
    check("clr_stage", int'(err_stage_o), 0);
    check("clr_overrun", int'(overrun_cnt_o), 0);

    trig = 1'b1;
    step();
    trig = 1'b0;
    adc_ack = 1'b1;
    step();
    adc_ack = 1'b0;
    pid_done = 1'b1;
    step();
    pid_done = 1'b0;
    check("dac_valid_pre_rst", int'(dac_valid_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_dac_valid", int'(dac_valid_o), 0);
    check("rst_async_hold", int'(gen_hold_o), 1);
    check("rst_async_busy", int'(busy_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    check("post_rst_busy", int'(busy_o), 0);
    check("post_rst_lat", int'(cycle_lat_o), 0);
    check("post_rst_overrun", int'(overrun_cnt_o), 0);
    run_cycle(0, 0, 0, 0, 1'b0, 3, 0, 0);

    repeat (3) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motor_loop_scheduler.md
# motor_loop_scheduler

Sequences one closed-loop motor update per trigger pulse from the motor trigger generator: ADC sample request, PID compute, DAC write, each as a handshake with its own timeout. Also configures the generator, holding it in preset while the loop is disabled and applying frequency changes only while disabled. Reports overruns, timeouts and per-cycle latency to the register bank.

## Interface
- TIMEOUT_CYC, 1000: maximum cycles spent in any handshake state (≥2).
- OVR_W, 16: overrun counter width.
- LAT_W, 16: latency counter width.
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- loop_en_i  in  1  closed-loop enable (level).
- freq_sel_i  in  4  requested rate code: 0:128Hz, 1:256Hz, 2:512Hz, 3:1024Hz.
- err_clr_i  in  1  one-cycle pulse; clears sticky errors and the overrun counter.
- trig_i  in  1  generator trigger output.
- gen_hold_o  out  1  drives generator bias/preset input; 1 = hold.
- gen_freq_o  out  4  drives generator rate code.
- adc_req_o / adc_ack_i  out/in  1  sample request, held until ack.
- pid_start_o  out  1  one-cycle start pulse.
- pid_done_i  in  1  compute finished pulse.
- dac_valid_o / dac_ready_i  out/in  1  DAC write valid/ready.
- cycle_done_o  out  1  one-cycle pulse on successful cycle end.
- busy_o  out  1  state ≠ IDLE.
- err_to_o  out  1  sticky timeout flag.
- err_stage_o  out  2  stage of first timeout: 1 = SAMPLE, 2 = CALC, 3 = OUTPUT.
- overrun_cnt_o  out  OVR_W  saturating count of dropped triggers.
- cycle_lat_o  out  LAT_W  latency of last successful cycle.

## Operation
- Reset values: all outputs 0 except gen_hold_o = 1. State is IDLE.
- gen_hold_o is registered ~loop_en_i. gen_freq_o loads freq_sel_i every cycle while loop_en_i = 0; it is frozen while loop_en_i = 1.
- Trigger detect uses a rising edge: trig_i & ~trig_d, where trig_d resets to 1. A constant-high trig_i during hold therefore never triggers.
- IDLE: an edge with loop_en_i = 1 goes to SAMPLE and clears the latency counter. An edge with loop_en_i = 0 is ignored.
- SAMPLE: adc_req_o = 1. When adc_ack_i = 1, go to CALC.
- CALC: pid_start_o pulses on the first CALC cycle only. When pid_done_i = 1, go to OUTPUT. A pid_done_i in the entry cycle is accepted.
- OUTPUT: dac_valid_o = 1. When dac_ready_i = 1, go to IDLE. On that transition, pulse cycle_done_o next cycle and load cycle_lat_o.
- Timeout: a per-state counter clears on state entry. If a state reaches TIMEOUT_CYC cycles without a handshake, go to IDLE with all request outputs deasserted.
  - On timeout, set err_to_o. err_stage_o captures only the first timeout stage.
  - A handshake in the last allowed cycle wins over the timeout.
- Overrun: a trigger edge while state ≠ IDLE is dropped and increments overrun_cnt_o, saturating at all-ones.
- loop_en_i falling mid-cycle: the cycle completes or times out. There is no abort.
- err_clr_i clears err_to_o, err_stage_o and overrun_cnt_o. If it coincides with a new timeout or overrun, the new event wins.
- cycle_lat_o = clocks from the trigger-accept cycle to the DAC handshake cycle. The latency counter saturates at all-ones.

## Timing
- Trigger accept at T0 → adc_req_o high at T1.
- adc_ack_i at Tn → pid_start_o at Tn+1.
- pid_done_i at Tm → dac_valid_o at Tm+1.
- dac_ready_i at Tk → IDLE, cycle_done_o and updated cycle_lat_o at Tk+1.
- Minimum cycle is 4 clocks. A new trigger is accepted in the cycle after return to IDLE.
- All outputs are registered except none; there are no combinational in-to-out paths.
- Reset assertion mid-cycle drops all handshakes within the same cycle (asynchronous).

## Structure
- motor_sched_pkg: state enum (IDLE, SAMPLE, CALC, OUTPUT), stage codes, and rate-code constants 0–3.
- Sub-module motor_sched_timer: loadable timeout counter with clear-on-entry and an expired flag, parameterised by TIMEOUT_CYC.

## Test plan
- Nominal: loop_en = 1; trigger at T0; ack at T1; done 10 cycles after start; ready immediately → cycle_done_o at T14, cycle_lat_o = 13, no errors.
- Overrun: hold pid_done_i low for 300 cycles; apply 3 trigger edges meanwhile → overrun_cnt_o = 3; the cycle completes normally.
- Timeout: TIMEOUT_CYC = 1000; adc_ack_i never asserted → adc_req_o high exactly 1000 cycles, then IDLE, err_to_o = 1, err_stage_o = 1.
  - A second timeout in CALC leaves err_stage_o = 1.
  - err_clr_i clears all three error/overrun outputs.
- Enable sequencing: freq_sel_i = 3 with loop_en = 0, trig_i held high → gen_hold_o = 1, gen_freq_o = 3, no cycle.
  - Raise loop_en; change freq_sel_i to 0 → gen_freq_o stays 3; the first cycle starts only on the next rising edge.
- Async reset mid-OUTPUT: assert rst_n_i = 0 → dac_valid_o = 0 and gen_hold_o = 1 immediately. After release, state is IDLE and counters are 0.
- Boundary: dac_ready_i arrives in the 1000th OUTPUT cycle → success, cycle_done_o pulses, no timeout.
